ksa_param: RTL and testbench

Parametrised RC4 key-scheduling engine, the next generation of the fixed 24-bit `ksa`. It permutes the 256-byte S array held in the single-port `s_mem` according to a key of configurable length. It optionally performs the identity fill S[i]=i itself and tolerates memories with more than one cycle of read latency. It sits between the crack controller (en/rdy handshake) and `s_mem`, and replaces `ksa` in the parallel cracking lanes.

---
 rtl/arc4_pkg.sv | 20 ++
 rtl/ksa_param.sv | 178 +++++++++++++++++
 tb/tb_ksa_param.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// arc4_pkg: shared types and constants for the RC4 key-scheduling engine.
//   ksa_state_t : scheduler FSM states
//   S_SIZE      : number of entries in the S array
//   BYTE_W      : width of one S entry / key byte
package arc4_pkg;

  localparam int S_SIZE = 256;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RD_I,
    RD_J,
    WR_J,
    WR_I,
    DONE
  } ksa_state_t;

endpackage

// File: rtl/ksa_param.sv
// ksa_param: parametrised RC4 key-scheduling engine driving a single-port S memory.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   en      : start request, taken only while rdy=1
//   rdy     : idle and ready for en
//   key     : KEY_BYTES-byte key, byte 0 in the MSBs, captured on start
//   addr    : S memory address
//   rddata  : S memory read data, valid RD_LAT cycles after addr is first driven
//   wrdata  : S memory write data
//   wren    : S memory write enable
//
// state | meaning
// IDLE  | rdy=1, waiting for en
// FILL  | optional identity fill, one write S[i]=i per cycle
// RD_I  | addr=i for RD_LAT cycles
// RD_J  | take si, update j, addr=j for RD_LAT cycles
// WR_J  | take sj, write S[j]=si
// WR_I  | write S[i]=sj, advance i
// DONE  | one quiet cycle before rdy returns
import arc4_pkg::*;

module ksa_param #(
  parameter int KEY_BYTES = 3,
  parameter int INIT_FILL = 0,
  parameter int RD_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  output logic                      rdy,
  input  logic [8*KEY_BYTES-1:0]    key,
  output logic [BYTE_W-1:0]         addr,
  input  logic [BYTE_W-1:0]         rddata,
  output logic [BYTE_W-1:0]         wrdata,
  output logic                      wren
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam int KI_W  = 5;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [BYTE_W-1:0] LAST_I   = BYTE_W'(S_SIZE - 1);
  localparam logic [KI_W-1:0]   LAST_KI  = KI_W'(KEY_BYTES - 1);

  ksa_state_t               state_q, state_d;
  logic [BYTE_W-1:0]        i_q, i_d;
  logic [BYTE_W-1:0]        j_q, j_d;
  logic [BYTE_W-1:0]        si_q, si_d;
  logic [BYTE_W-1:0]        sj_q, sj_d;
  logic [KI_W-1:0]          ki_q, ki_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [8*KEY_BYTES-1:0]   key_q, key_d;
  logic                     rdy_q, rdy_d;

  logic [BYTE_W-1:0]        key_byte;
  logic [BYTE_W-1:0]        j_new;

  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (ki_q == KI_W'(k)) key_byte = key_q[8*(KEY_BYTES-k)-1 -: 8];
    end
  end

  // rddata carries S[i] during the first RD_J cycle, so j is formed
  // combinationally there and the same value is put on addr straight away.
  assign j_new = j_q + rddata + key_byte;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    ki_d    = ki_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    rdy_d   = rdy_q;
    addr    = '0;
    wrdata  = '0;
    wren    = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && rdy_q) begin
          key_d   = key;
          i_d     = '0;
          j_d     = '0;
          ki_d    = '0;
          cnt_d   = CNT_LOAD;
          rdy_d   = 1'b0;
          state_d = (INIT_FILL != 0) ? FILL : RD_I;
        end
      end
      FILL: begin
        addr   = i_q;
        wrdata = i_q;
        wren   = 1'b1;
        i_d    = i_q + 8'd1;
        if (i_q == LAST_I) begin
          cnt_d   = CNT_LOAD;
          state_d = RD_I;
        end
      end
      RD_I: begin
        addr = i_q;
        if (cnt_q == '0) begin
          cnt_d   = CNT_LOAD;
          state_d = RD_J;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_J: begin
        if (cnt_q == CNT_LOAD) begin
          si_d = rddata;
          j_d  = j_new;
          addr = j_new;
        end else begin
          addr = j_q;
        end
        if (cnt_q == '0) state_d = WR_J;
        else             cnt_d   = cnt_q - 1'b1;
      end
      WR_J: begin
        addr    = j_q;
        wrdata  = si_q;
        wren    = 1'b1;
        sj_d    = rddata;
        state_d = WR_I;
      end
      WR_I: begin
        addr   = i_q;
        wrdata = sj_q;
        wren   = 1'b1;
        if (i_q == LAST_I) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 8'd1;
          ki_d    = (ki_q == LAST_KI) ? '0 : ki_q + 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = RD_I;
        end
      end
      DONE: begin
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      ki_q    <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      ki_q    <= ki_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      rdy_q   <= rdy_d;
    end
  end

  assign rdy = rdy_q;

endmodule

// File: tb/tb_ksa_param.sv
// tb_ksa_param: four ksa_param lanes with different parameter sets, each
// attached to its own S memory model with configurable read latency.
module tb_ksa_param;

  localparam int NL = 4;
  localparam int KB_P [NL] = '{3, 16, 3, 1};
  localparam int IF_P [NL] = '{0, 1, 0, 0};
  localparam int RL_P [NL] = '{1, 1, 3, 1};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         en_a     [NL];
  logic         rdy_a    [NL];
  logic [127:0] key_a    [NL];
  logic [7:0]   addr_a   [NL];
  logic [7:0]   rddata_a [NL];
  logic [7:0]   wrdata_a [NL];
  logic         wren_a   [NL];
  logic         ld_req   [NL];
  logic [7:0]   chk_data [NL];
  int           wcnt_a   [NL];
  logic         ld_ff;
  logic [7:0]   chk_addr;

  int errs   = 0;
  int checks = 0;
  logic [7:0] ref_s [256];

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int KB = KB_P[g];
    localparam int RL = RL_P[g];
    logic [7:0] mem  [256];
    logic [7:0] pipe [4];
    int wcnt = 0;

    ksa_param #(.KEY_BYTES(KB), .INIT_FILL(IF_P[g]), .RD_LAT(RL)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en_a[g]),
      .rdy    (rdy_a[g]),
      .key    (key_a[g][8*KB-1:0]),
      .addr   (addr_a[g]),
      .rddata (rddata_a[g]),
      .wrdata (wrdata_a[g]),
      .wren   (wren_a[g])
    );

    always @(posedge clk) begin
      if (ld_req[g]) begin
        for (int k = 0; k < 256; k++) mem[k] <= ld_ff ? 8'hFF : 8'(k);
        wcnt <= 0;
      end else if (wren_a[g]) begin
        mem[addr_a[g]] <= wrdata_a[g];
        wcnt <= wcnt + 1;
      end
      pipe[0] <= mem[addr_a[g]];
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    assign rddata_a[g] = pipe[RL-1];
    assign chk_data[g] = mem[chk_addr];
    assign wcnt_a[g]   = wcnt;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $display("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  // Straightforward software KSA on the expected starting contents.
  task automatic ref_ksa(input int n, input logic [255:0] k, input bit start_ff, input bit fill);
    int j;
    logic [7:0] kb, t;
    for (int i = 0; i < 256; i++) ref_s[i] = (start_ff && !fill) ? 8'hFF : 8'(i);
    j = 0;
    for (int i = 0; i < 256; i++) begin
      kb = 8'(k >> (8 * (n - 1 - (i % n))));
      j = (j + int'(ref_s[i]) + int'(kb)) % 256;
      t = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
    end
  endtask

  task automatic load(input int g, input bit ff);
    @(negedge clk);
    ld_ff = ff;
    ld_req[g] = 1'b1;
    @(negedge clk);
    ld_req[g] = 1'b0;
  endtask

  task automatic check_s(input int g, input string tag);
    int mism;
    mism = 0;
    for (int k = 0; k < 256; k++) begin
      chk_addr = 8'(k);
      #1;
      if (chk_data[g] !== ref_s[k]) mism++;
    end
    check(tag, mism, 0);
  endtask

  task automatic run(input int g, input logic [127:0] k, output int lat);
    key_a[g] = k;
    @(negedge clk);
    en_a[g] = 1'b1;
    @(posedge clk);
    #1 en_a[g] = 1'b0;
    lat = 0;
    while (lat < 5000 && !rdy_a[g]) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic full_test(input int g, input logic [127:0] k, input bit ff,
                           input int exp_lat, input int exp_w, input string tag);
    int lat;
    load(g, ff);
    ref_ksa(KB_P[g], 256'(k), ff, IF_P[g] != 0);
    run(g, k, lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " writes"}, wcnt_a[g], exp_w);
    check_s(g, {tag, " S"});
  endtask

  initial begin
    int lat;
    logic [127:0] rk;
    for (int g = 0; g < NL; g++) begin
      en_a[g] = 1'b0;
      ld_req[g] = 1'b0;
      key_a[g] = '0;
    end
    ld_ff = 1'b0;
    chk_addr = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset rdy", rdy_a[0], 1);
    check("reset wren", wren_a[0], 0);
    check("reset addr", addr_a[0], 0);
    check("reset wrdata", wrdata_a[0], 0);
    check("reset rdy lane1", rdy_a[1], 1);
    #20 rst_n = 1'b1;

    full_test(0, 128'h000155, 1'b0, 1025, 512, "default");
    full_test(1, 128'h000102030405060708090A0B0C0D0E0F, 1'b1, 1281, 768, "kb16 fill");
    full_test(2, 128'hFFFFFF, 1'b0, 2049, 512, "rdlat3");
    full_test(3, 128'h00, 1'b0, 1025, 512, "kb1 zero");

    rk = 128'($urandom) & 128'hFFFFFF;
    full_test(0, rk, 1'b0, 1025, 512, "rand kb3");
    rk = {$urandom, $urandom, $urandom, $urandom};
    full_test(1, rk, 1'b1, 1281, 768, "rand kb16");
    rk = 128'($urandom_range(0, 255));
    full_test(3, rk, 1'b0, 1025, 512, "rand kb1");
    rk = 128'($urandom) & 128'hFFFFFF;
    full_test(2, rk, 1'b0, 2049, 512, "rand rdlat3");

    // Abort a run part-way with an asynchronous reset.
    load(0, 1'b0);
    key_a[0] = 128'h123456;
    @(negedge clk);
    en_a[0] = 1'b1;
    @(posedge clk);
    #1 en_a[0] = 1'b0;
    repeat (300) @(posedge clk);
    #2;
    check("midrun busy", rdy_a[0], 0);
    rst_n = 1'b0;
    #1;
    check("async rdy", rdy_a[0], 1);
    check("async wren", wren_a[0], 0);
    check("async addr", addr_a[0], 0);
    check("async wrdata", wrdata_a[0], 0);
    #10 rst_n = 1'b1;
    full_test(0, 128'h000155, 1'b0, 1025, 512, "after reset");

    // en held high across a whole run.
    load(0, 1'b0);
    key_a[0] = 128'h000155;
    @(negedge clk);
    en_a[0] = 1'b1;
    @(posedge clk);
    #1 lat = 0;
    while (lat < 5000 && !rdy_a[0]) begin
      @(posedge clk);
      #1 lat++;
    end
    check("held latency", lat, 1025);
    check("held writes", wcnt_a[0], 512);
    check("held quiet0", wren_a[0], 0);
    @(posedge clk);
    #1;
    check("held restart", rdy_a[0], 0);
    check("held quiet1", wren_a[0], 0);
    @(posedge clk);
    #1;
    check("held quiet2", wren_a[0], 0);
    en_a[0] = 1'b0;
    @(posedge clk);
    #1;
    check("held second run write", wren_a[0], 1);
    rst_n = 1'b0;
    #3 rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
